bist_misr: RTL
==============

# bist_misr

Multiple-input signature register and pass/fail comparator for the per-scan BIST datapath. Sits directly downstream of the CUT: compacts the CUT's observable outputs every cycle the BIST controller asserts `running`, then compares the final signature against a golden value when `finish` pulses. Drives the top-level `pass_nfail` output.

## Interface
- `DATA_W`, 9: compacted input width, ordered {cut_read_a[4:0], cut_lclk, cut_fz_L, cut_test_out[1:0]}, MSB first; must be ≤ SIG_W
- `SIG_W`, 16: signature width
- `POLY`, 16'h1021: feedback polynomial; bit 0 must be 1
- `SEED`, 16'h0000: value loaded on `init`
- `GOLDEN`, 16'h0000: expected final signature, set per CUT build
- `EXPECTED_CYCLES`, 16'd0: required compaction count, used only with BIST_MISR_CYCLE_CHECK_EN
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `init`  in  1  controller: load SEED, clear result
- `running`  in  1  controller: compact `data_in` this cycle
- `finish`  in  1  controller: single-cycle pulse, evaluate signature
- `data_in`  in  DATA_W  concatenated CUT outputs
- `signature`  out  SIG_W  current signature register
- `sig_valid`  out  1  high while in DONE
- `pass_nfail`  out  1  1 = signature matched; valid only when `sig_valid`=1

## Operation
- States: IDLE, COMPACT, DONE (encoding from bist_pkg).
- IDLE: `init` -> signature<=SEED, state COMPACT. `running`/`finish` ignored.
- COMPACT: if `running`: signature <= {signature[SIG_W-2:0],1'b0} ^ (signature[SIG_W-1] ? POLY : 0) ^ zero-extended `data_in`. `running` low -> hold.
- COMPACT + `finish`: state DONE; pass_nfail <= (signature == GOLDEN), using the register value before this edge; `data_in` of the finish cycle is not compacted even if `running`=1.
- DONE: signature, pass_nfail held (sticky). `running`/`finish` ignored. `init` -> reload SEED, pass_nfail<=0, state COMPACT.
- Priority on same edge: reset > init > finish > running.
- `init` in COMPACT restarts compaction from SEED (controller re-entry).
- `reset` at any point: state IDLE, signature 0, pass_nfail 0, sig_valid 0, counter 0.

## Timing
- Reset values: signature=0, sig_valid=0, pass_nfail=0.
- `init` at edge N: signature=SEED after N.
- Compaction: one `data_in` sample per `running` edge, result visible next cycle; zero-bubble.
- `finish` at edge N: sig_valid=1 and pass_nfail valid after N (1-cycle latency); both remain until `init` or `reset`.
- All outputs registered; no combinational input-to-output path.

## Configuration
- `BIST_MISR_CYCLE_CHECK_EN` defined: adds 16-bit saturating counter (cleared on init/reset, +1 per compacted cycle, stops at 16'hFFFF); pass requires signature==GOLDEN AND count==EXPECTED_CYCLES.
- Undefined: no counter logic; pass depends on signature only; EXPECTED_CYCLES unused.

## Structure
- bist_pkg: state encoding constants, default POLY/SEED, DATA_W field ordering constants.
- Sub-module `misr_core`: pure signature register (load, enable, data, POLY/SEED params); bist_misr holds FSM, comparator, optional counter.

## Test plan
- Reset held 2 cycles -> signature=16'h0000, sig_valid=0, pass_nfail=0; `running`=1 in IDLE leaves signature 0.
- SEED=16'hFFFF, init pulse -> signature=16'hFFFF next cycle, state COMPACT.
- From signature 0, running=1, data_in=9'h001 -> 16'h0001; from 16'h8000, data_in=0 -> 16'h1021.
- GOLDEN set to model-computed value after 20 cycles, finish pulse -> next cycle sig_valid=1, pass_nfail=1; flip one data bit in run -> pass_nfail=0.
- finish and running on same edge -> final sample not compacted; init and finish same edge -> reload SEED, sig_valid=0.
- With BIST_MISR_CYCLE_CHECK_EN, EXPECTED_CYCLES=20, finish after 19 correct-signature cycles -> pass_nfail=0; reset mid-COMPACT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared constants for the per-scan BIST signature path: FSM state encoding,
// default MISR polynomial/seed and the bit layout of the compacted CUT outputs.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int          DEF_SIG_W = 16;
    localparam logic [15:0] DEF_POLY  = 16'h1021;
    localparam logic [15:0] DEF_SEED  = 16'h0000;

    // data_in layout, MSB first: {cut_read_a[4:0], cut_lclk, cut_fz_L, cut_test_out[1:0]}
    localparam int FLD_TEST_OUT_LSB = 0;
    localparam int FLD_FZ_L         = 2;
    localparam int FLD_LCLK         = 3;
    localparam int FLD_READ_A_LSB   = 4;
    localparam int FLD_READ_A_MSB   = 8;
    localparam int DEF_DATA_W       = FLD_READ_A_MSB + 1;

endpackage

// File: rtl/misr_core.sv
// Plain multiple-input signature register: synchronous load of SEED, and one
// shift-with-feedback step that folds in data_in whenever enable is high.
module misr_core
    import bist_pkg::*;
#(
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               SIG_W  = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              enable,
    input  logic [DATA_W-1:0] data_in,
    output logic [SIG_W-1:0]  signature
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] feedback;
    logic [SIG_W-1:0] sig_next;

    assign feedback = sig_q[SIG_W-1] ? POLY : '0;
    assign sig_next = {sig_q[SIG_W-2:0], 1'b0} ^ feedback ^ SIG_W'(data_in);

    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sig_q <= '0;
        end else if (load) begin
            sig_q <= SEED;
        end else if (enable) begin
            sig_q <= sig_next;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/bist_misr.sv
// BIST signature compactor and pass/fail comparator driving pass_nfail.
// Optional feature: define BIST_MISR_CYCLE_CHECK_EN to also require an exact compaction count.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               DATA_W          = DEF_DATA_W,
    parameter int               SIG_W           = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY            = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED            = DEF_SEED,
    parameter logic [SIG_W-1:0] GOLDEN          = '0,
    parameter logic [15:0]      EXPECTED_CYCLES = 16'd0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init,
    input  logic              running,
    input  logic              finish,
    input  logic [DATA_W-1:0] data_in,
    output logic [SIG_W-1:0]  signature,
    output logic              sig_valid,
    output logic              pass_nfail
);

    state_t state, state_nx;
    logic   pass_q, pass_nx;
    logic   load, enable;
    logic   match;

    misr_core #(
        .DATA_W (DATA_W),
        .SIG_W  (SIG_W),
        .POLY   (POLY),
        .SEED   (SEED)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .enable    (enable),
        .data_in   (data_in),
        .signature (signature)
    );

`ifdef BIST_MISR_CYCLE_CHECK_EN
    logic [15:0] cycle_cnt;

    always_ff @(posedge clock) begin
        if (reset || load) begin
            cycle_cnt <= '0;
        end else if (enable && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end

    assign match = (signature == GOLDEN) && (cycle_cnt == EXPECTED_CYCLES);
`else
    logic unused_expected;
    assign unused_expected = ^EXPECTED_CYCLES;
    assign match           = (signature == GOLDEN);
`endif

    // Priority inside each state: init > finish > running.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a latch.
        state_nx = state;
        pass_nx  = pass_q;
        load     = 1'b0;
        enable   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (init) begin
                    load     = 1'b1;
                    pass_nx  = 1'b0;
                    state_nx = ST_COMPACT;
                end
            end
            ST_COMPACT: begin
                if (init) begin
                    load    = 1'b1;
                    pass_nx = 1'b0;
                end else if (finish) begin
                    pass_nx  = match;
                    state_nx = ST_DONE;
                end else if (running) begin
                    enable = 1'b1;
                end
            end
            ST_DONE: begin
                if (init) begin
                    load     = 1'b1;
                    pass_nx  = 1'b0;
                    state_nx = ST_COMPACT;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ST_IDLE;
            pass_q <= 1'b0;
        end else begin
            state  <= state_nx;
            pass_q <= pass_nx;
        end
    end

    assign sig_valid  = (state == ST_DONE);
    assign pass_nfail = pass_q;

endmodule
